// File: rtl/pixel_readout.sv
// Pixel array row readout: tracks erase/expose/convert/read phases, buffers one row and streams it out pixel by pixel.
// Optional build macro PIXEL_READOUT_GRAY_EN converts Gray-coded column samples to binary on capture.
module pixel_readout #(
    parameter int ROW = 4,
    parameter int COL = 4,
    parameter int DW  = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   erase,
    input  logic                   expose,
    input  logic                   convert,
    input  logic [ROW-1:0]         read,
    input  logic [COL*DW-1:0]      col_data,
    input  logic                   pix_ready,
    output logic                   pix_valid,
    output logic [DW-1:0]          pix_data,
    output logic [$clog2(ROW)-1:0] pix_row,
    output logic [$clog2(COL)-1:0] pix_col,
    output logic                   frame_done,
    output logic [7:0]             frame_cnt,
    output logic                   proto_err,
    output logic                   overrun
);
    localparam int RW = $clog2(ROW);
    localparam int CW = $clog2(COL);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ERASED    = 3'd1;
    localparam logic [2:0] EXPOSED   = 3'd2;
    localparam logic [2:0] CONVERTED = 3'd3;
    localparam logic [2:0] READING   = 3'd4;

    logic [2:0]    state;
    logic          rd_any_p1;
    logic [RW-1:0] exp_row;
    logic [RW-1:0] rd_idx;
    logic [DW-1:0] rowbuf_p1 [COL];
    logic          rd_edge;
    logic          rd_onehot;
    logic          rd_err;
    logic          phase_err;
    logic          xfer;
    logic          last_col;
    logic          buf_free;
    logic          cap;
    logic [CW-1:0] nxt_col;

    function automatic logic [DW-1:0] sample_conv(input logic [DW-1:0] s);
        logic [DW-1:0] b;
`ifdef PIXEL_READOUT_GRAY_EN
        b[DW-1] = s[DW-1];
        for (int i = DW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ s[i];
        end
`else
        b = s;
`endif
        return b;
    endfunction

    always_comb begin
        rd_idx = '0;
        for (int r = ROW - 1; r >= 0; r--) begin
            if (read[r]) begin
                rd_idx = RW'(r);
            end
        end
        rd_edge   = (|read) & ~rd_any_p1;
        rd_onehot = (|read) && ((read & (read - ROW'(1))) == '0);
        rd_err    = ~rd_onehot || (rd_idx != exp_row) ||
                    ((state != CONVERTED) && (state != READING));
        phase_err = (expose && (state != ERASED) && (state != EXPOSED)) ||
                    (convert && (state != EXPOSED) && (state != CONVERTED));
        xfer      = pix_valid & pix_ready;
        last_col  = (pix_col == CW'(COL - 1));
        nxt_col   = pix_col + CW'(1);
        // The buffer frees up in the same cycle its last pixel leaves.
        buf_free  = ~pix_valid | (xfer & last_col);
        cap       = rd_edge & ~erase & buf_free;
    end

    // Row buffer stage: data only, no reset; emptiness is tracked by pix_valid.
    always_ff @(posedge clock) begin
        if (cap) begin
            for (int c = 0; c < COL; c++) begin
                rowbuf_p1[c] <= sample_conv(col_data[c*DW +: DW]);
            end
        end
    end

    // Control and output stage.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rd_any_p1  <= 1'b1;
            exp_row    <= '0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_row    <= '0;
            pix_col    <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            proto_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rd_any_p1  <= |read;
            frame_done <= 1'b0;
            if (erase) begin
                state     <= ERASED;
                proto_err <= 1'b0;
                overrun   <= 1'b0;
                exp_row   <= '0;
                pix_valid <= 1'b0;
            end else begin
                if (phase_err) begin
                    proto_err <= 1'b1;
                end
                if (expose && state == ERASED) begin
                    state <= EXPOSED;
                end
                if (convert && state == EXPOSED) begin
                    state <= CONVERTED;
                end
                if (xfer) begin
                    if (last_col) begin
                        pix_valid <= 1'b0;
                        if (pix_row == RW'(ROW - 1)) begin
                            frame_done <= 1'b1;
                            frame_cnt  <= frame_cnt + 8'd1;
                            state      <= IDLE;
                        end
                    end else begin
                        pix_col  <= nxt_col;
                        pix_data <= rowbuf_p1[nxt_col];
                    end
                end
                if (rd_edge) begin
                    exp_row <= rd_idx + RW'(1);
                    if (rd_err) begin
                        proto_err <= 1'b1;
                    end
                    if (state == CONVERTED) begin
                        state <= READING;
                    end
                    if (buf_free) begin
                        pix_valid <= 1'b1;
                        pix_row   <= rd_idx;
                        pix_col   <= '0;
                        pix_data  <= sample_conv(col_data[DW-1:0]);
                    end else begin
                        overrun <= 1'b1;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout with a pixel scoreboard; honours PIXEL_READOUT_GRAY_EN when defined.
module tb_pixel_readout;
    localparam int ROW = 4;
    localparam int COL = 4;
    localparam int DW  = 8;
`ifdef PIXEL_READOUT_GRAY_EN
    localparam logic [7:0] GRAY_EXP = 8'd128;
`else
    localparam logic [7:0] GRAY_EXP = 8'd192;
`endif

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            erase = 1'b0;
    logic            expose = 1'b0;
    logic            convert = 1'b0;
    logic [ROW-1:0]  read = '0;
    logic [COL*DW-1:0] col_data = '0;
    logic            pix_ready = 1'b0;
    logic            pix_valid;
    logic [DW-1:0]   pix_data;
    logic [1:0]      pix_row;
    logic [1:0]      pix_col;
    logic            frame_done;
    logic [7:0]      frame_cnt;
    logic            proto_err;
    logic            overrun;

    int          errors = 0;
    int          checks = 0;
    int          fd_cnt = 0;
    bit          bp = 1'b0;
    logic [31:0] sb [$];
    logic        hold_v = 1'b0;
    logic [31:0] held = '0;

    pixel_readout #(.ROW(ROW), .COL(COL), .DW(DW)) dut (
        .clock(clock), .reset(reset), .erase(erase), .expose(expose), .convert(convert),
        .read(read), .col_data(col_data), .pix_ready(pix_ready), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_row(pix_row), .pix_col(pix_col), .frame_done(frame_done),
        .frame_cnt(frame_cnt), .proto_err(proto_err), .overrun(overrun)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] pack(input logic [7:0] r, input logic [7:0] c, input logic [7:0] d);
        return {8'h00, r, c, d};
    endfunction

    // Reference decode: binary bit i is the XOR of all Gray bits at or above i.
    function automatic logic [7:0] gdec(input logic [7:0] v);
        logic [7:0] b;
`ifdef PIXEL_READOUT_GRAY_EN
        for (int i = 0; i < 8; i++) b[i] = ^(v >> i);
`else
        b = v;
`endif
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
            if (bp) pix_ready = ~pix_ready;
        end
    endtask

    task automatic read_row(input int r, input logic [3:0] rd, input logic [31:0] data, input int npush);
        for (int c = 0; c < COL; c++) begin
            col_data[c*DW +: DW] = data[c*8 +: 8];
            if (c < npush) sb.push_back(pack(8'(r), 8'(c), gdec(data[c*8 +: 8])));
        end
        read = rd;
        step(1);
        read = '0;
    endtask

    task automatic phases();
        erase = 1'b1;   step(1); erase = 1'b0;
        expose = 1'b1;  step(1); expose = 1'b0;
        convert = 1'b1; step(1); convert = 1'b0;
        step(1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(pix_valid), 32'd0);
        chk({tag, "_data"}, 32'(pix_data), 32'd0);
        chk({tag, "_row"}, 32'(pix_row), 32'd0);
        chk({tag, "_col"}, 32'(pix_col), 32'd0);
        chk({tag, "_fdone"}, 32'(frame_done), 32'd0);
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_perr"}, 32'(proto_err), 32'd0);
        chk({tag, "_ovr"}, 32'(overrun), 32'd0);
    endtask

    // Scoreboard monitor: a pixel transfers at the next rising edge when valid and ready are high here.
    always @(negedge clock) begin
        logic [31:0] cur;
        logic [31:0] e;
        cur = pack(8'(pix_row), 8'(pix_col), pix_data);
        if (reset && frame_done) fd_cnt++;
        if (reset && !erase) begin
            if (hold_v && pix_valid) chk("hold_stable", cur, held);
            if (pix_valid && pix_ready) begin
                checks++;
                assert (sb.size() != 0) else begin
                    errors++;
                    $error("FAIL pix_extra: observed pixel %0h required none", cur);
                end
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("pixel", cur, e);
                end
            end
            hold_v = pix_valid && !pix_ready;
            held = cur;
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish required finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset = 1'b0;
        #1 chk_reset_outputs("reset0");
        step(2);
        reset = 1'b1;
        pix_ready = 1'b1;
        step(1);

        // Expose straight out of IDLE is a protocol error.
        expose = 1'b1; step(1); expose = 1'b0;
        chk("expose_no_erase", 32'(proto_err), 32'd1);

        // Normal frame.
        phases();
        chk("erase_clears_perr", 32'(proto_err), 32'd0);
        for (int r = 0; r < ROW; r++) begin
            if (r == 0) chk("valid_before_cap", 32'(pix_valid), 32'd0);
            read_row(r, 4'(1 << r), $urandom, 4);
            if (r == 0) begin
                chk("valid_after_cap", 32'(pix_valid), 32'd1);
                chk("first_row", 32'(pix_row), 32'd0);
                chk("first_col", 32'(pix_col), 32'd0);
            end
            step(7);
        end
        step(2);
        chk("norm_fdone_cnt", 32'(fd_cnt), 32'd1);
        chk("norm_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("norm_perr", 32'(proto_err), 32'd0);
        chk("norm_ovr", 32'(overrun), 32'd0);
        chk("norm_sb_empty", 32'(sb.size()), 32'd0);

        // Backpressure: pix_ready toggles every cycle.
        bp = 1'b1;
        phases();
        for (int r = 0; r < ROW; r++) begin
            read_row(r, 4'(1 << r), $urandom, 4);
            step(11);
        end
        step(4);
        bp = 1'b0;
        pix_ready = 1'b1;
        step(2);
        chk("bp_fdone_cnt", 32'(fd_cnt), 32'd2);
        chk("bp_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("bp_sb_empty", 32'(sb.size()), 32'd0);

        // Overrun: row 1 arrives while row 0 is still buffered.
        phases();
        pix_ready = 1'b0;
        read_row(0, 4'b0001, $urandom, 4);
        step(1);
        read_row(1, 4'b0010, $urandom, 0);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_perr", 32'(proto_err), 32'd0);
        chk("ovr_row_kept", 32'(pix_row), 32'd0);
        pix_ready = 1'b1;
        step(8);
        chk("ovr_sb_empty", 32'(sb.size()), 32'd0);
        chk("ovr_idle", 32'(pix_valid), 32'd0);

        // Protocol errors.
        phases();
        chk("erase_clears_ovr", 32'(overrun), 32'd0);
        read_row(0, 4'b0011, $urandom, 4);
        chk("perr_not_onehot", 32'(proto_err), 32'd1);
        chk("perr_row_lowest", 32'(pix_row), 32'd0);
        step(6);
        erase = 1'b1; step(1); erase = 1'b0;
        chk("perr_cleared", 32'(proto_err), 32'd0);
        read_row(0, 4'b0001, $urandom, 4);
        chk("perr_read_early", 32'(proto_err), 32'd1);
        step(6);
        phases();
        chk("perr_cleared2", 32'(proto_err), 32'd0);
        read_row(2, 4'b0100, $urandom, 4);
        chk("perr_wrong_row", 32'(proto_err), 32'd1);
        chk("perr_actual_row", 32'(pix_row), 32'd2);
        step(6);
        chk("perr_sb_empty", 32'(sb.size()), 32'd0);

        // Abort with erase during row 2.
        phases();
        read_row(0, 4'b0001, $urandom, 4);
        step(7);
        read_row(1, 4'b0010, $urandom, 4);
        step(7);
        read_row(2, 4'b0100, $urandom, 1);
        step(1);
        erase = 1'b1; step(1); erase = 1'b0;
        chk("abort_valid", 32'(pix_valid), 32'd0);
        chk("abort_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("abort_no_fdone", 32'(fd_cnt), 32'd2);
        chk("abort_sb_empty", 32'(sb.size()), 32'd0);

        // Reset mid-row.
        expose = 1'b1;  step(1); expose = 1'b0;
        convert = 1'b1; step(1); convert = 1'b0;
        pix_ready = 1'b0;
        read_row(0, 4'b0001, 32'h8181_8181, 0);
        chk("midrow_valid", 32'(pix_valid), 32'd1);
        reset = 1'b0;
        #1 chk_reset_outputs("midrow_rst");
        step(2);
        reset = 1'b1;
        pix_ready = 1'b1;
        step(6);
        chk("post_rst_quiet", 32'(pix_valid), 32'd0);
        chk("post_rst_sb", 32'(sb.size()), 32'd0);

        // Gray / plain sample conversion.
        phases();
        read_row(0, 4'b0001, 32'h5A3C_96C0, 4);
        chk("gray_pix0", 32'(pix_data), 32'(GRAY_EXP));
        step(6);
        chk("gray_sb_empty", 32'(sb.size()), 32'd0);
        chk("gray_frame_cnt", 32'(frame_cnt), 32'd0);
        chk("gray_perr", 32'(proto_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
